// File: rtl/tmr_clk_sel_ctrl_if.sv
// Bus between the timer front-end and the clock-select controller.
// The i_/o_ prefixes are from the controller's point of view.
interface tmr_clk_sel_ctrl_if;
   logic [3:0] i_clk_in;
   logic       i_tmr_en;
   logic       i_cks_wr;
   logic [1:0] i_cks_wdata;
   logic       o_cnt_en;
   logic [1:0] o_cks_cur;
   logic       o_sw_busy;
   logic       o_wr_err;
   logic       o_clk_fault;

   modport master (
      output i_clk_in, i_tmr_en, i_cks_wr, i_cks_wdata,
      input  o_cnt_en, o_cks_cur, o_sw_busy, o_wr_err, o_clk_fault
   );

   modport slave (
      input  i_clk_in, i_tmr_en, i_cks_wr, i_cks_wdata,
      output o_cnt_en, o_cks_cur, o_sw_busy, o_wr_err, o_clk_fault
   );
endinterface

// File: rtl/tmr_clk_sel_ctrl.sv
// Timer clock-source selector: turns rises of the selected divided clock into 1-cycle count
// enables, switches sources glitch-free (drain old tick, align on new) and flags stalled sources.
module tmr_clk_sel_ctrl #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              i_sys_clk,
   input  logic              i_sys_rst_n,
   tmr_clk_sel_ctrl_if.slave bus
);
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StRun, StSwDrain, StSwArm} state_e;

   state_e          r_state, w_state_nxt;
   logic [3:0]      r_clk_d;
   logic [1:0]      r_cks_cur, w_cks_nxt;
   logic [1:0]      r_pend, w_pend_nxt;
   logic [CntW-1:0] r_cnt, w_cnt_nxt;
   logic            r_cnt_en, w_cnt_en_nxt;
   logic            r_wr_err, w_wr_err_nxt;
   logic            r_clk_fault, w_fault_nxt;
   logic [3:0]      w_rise;
   logic            w_rise_cur, w_timeout, w_busy;

   assign w_rise     = bus.i_clk_in & ~r_clk_d;
   assign w_rise_cur = w_rise[r_cks_cur];
   assign w_busy     = (r_state == StSwDrain) || (r_state == StSwArm);
   assign w_timeout  = (r_cnt == CntW'(TIMEOUT - 1)) && !w_rise_cur;

   always_comb begin
      w_state_nxt  = r_state;
      w_cks_nxt    = r_cks_cur;
      w_pend_nxt   = r_pend;
      w_cnt_nxt    = '0;
      w_cnt_en_nxt = 1'b0;
      w_wr_err_nxt = w_busy && bus.i_cks_wr;
      w_fault_nxt  = r_clk_fault;
      if (r_state == StIdle) begin
         if (bus.i_cks_wr) begin
            w_cks_nxt   = bus.i_cks_wdata;
            w_fault_nxt = 1'b0;
         end
         if (bus.i_tmr_en) w_state_nxt = StRun;
      end else if (w_timeout) begin
         w_fault_nxt = 1'b1;
         w_state_nxt = StIdle;
      end else if (!bus.i_tmr_en) begin
         // Disable wins; a pending switch completes immediately.
         w_state_nxt  = StIdle;
         w_cnt_en_nxt = w_rise_cur && (r_state != StSwArm);
         if (w_busy) begin
            w_cks_nxt = r_pend;
         end else if (bus.i_cks_wr) begin
            w_cks_nxt   = bus.i_cks_wdata;
            w_fault_nxt = 1'b0;
         end
      end else begin
         w_cnt_nxt = w_rise_cur ? '0 : r_cnt + CntW'(1);
         unique case (r_state)
            StRun: begin
               w_cnt_en_nxt = w_rise_cur;
               if (bus.i_cks_wr && (bus.i_cks_wdata != r_cks_cur)) begin
                  w_pend_nxt  = bus.i_cks_wdata;
                  w_state_nxt = StSwDrain;
                  w_cnt_nxt   = '0;
               end
            end
            StSwDrain: begin
               if (w_rise_cur) begin
                  w_cnt_en_nxt = 1'b1;
                  w_cks_nxt    = r_pend;
                  w_state_nxt  = StSwArm;
               end
            end
            StSwArm: begin
               // First new-source rise only aligns phase.
               if (w_rise_cur) w_state_nxt = StRun;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst_n) begin
         r_state     <= StIdle;
         r_clk_d     <= '0;
         r_cks_cur   <= '0;
         r_pend      <= '0;
         r_cnt       <= '0;
         r_cnt_en    <= 1'b0;
         r_wr_err    <= 1'b0;
         r_clk_fault <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_clk_d     <= bus.i_clk_in;
         r_cks_cur   <= w_cks_nxt;
         r_pend      <= w_pend_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cnt_en    <= w_cnt_en_nxt;
         r_wr_err    <= w_wr_err_nxt;
         r_clk_fault <= w_fault_nxt;
      end
   end

   assign bus.o_cnt_en    = r_cnt_en;
   assign bus.o_cks_cur   = r_cks_cur;
   assign bus.o_sw_busy   = w_busy;
   assign bus.o_wr_err    = r_wr_err;
   assign bus.o_clk_fault = r_clk_fault;
endmodule

// File: tb/tb_tmr_clk_sel_ctrl.sv
// Scoreboard bench for tmr_clk_sel_ctrl: a behavioural model queues the expected outputs per
// cycle, an independent monitor compares them against the DUT on the falling edge.
module tb_tmr_clk_sel_ctrl;
   localparam int unsigned TIMEOUT = 64;

   typedef struct packed {
      logic       cnt_en;
      logic [1:0] cks_cur;
      logic       sw_busy;
      logic       wr_err;
      logic       clk_fault;
   } exp_t;

   typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_ARM} mode_t;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   tmr_clk_sel_ctrl_if bus ();

   tmr_clk_sel_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .i_sys_clk  (sys_clk),
      .i_sys_rst_n(sys_rst_n),
      .bus        (bus)
   );

   always #5 sys_clk = ~sys_clk;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          tick_cnt = 0;
   int unsigned phase = 0;
   logic [3:0]  stall_mask = '0;

   // Reference model state.
   mode_t      m_mode = M_IDLE;
   logic [3:0] m_prev = '0;
   int         m_cks = 0, m_pend = 0, m_wait = 0;
   bit         m_tick = 0, m_err = 0, m_fault = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Source periods 2/4/16/32 sys_clk cycles.
   function automatic logic [3:0] div_clocks(input int unsigned p);
      div_clocks = {p[4], p[3], p[1], p[0]};
   endfunction

   task automatic model_step();
      logic [3:0] rise;
      bit         r, sw;
      if (!sys_rst_n) begin
         m_mode = M_IDLE; m_prev = '0; m_cks = 0; m_pend = 0; m_wait = 0;
         m_tick = 0; m_err = 0; m_fault = 0;
         return;
      end
      rise   = bus.i_clk_in & ~m_prev;
      r      = rise[m_cks];
      m_prev = bus.i_clk_in;
      m_tick = 0;
      m_err  = 0;
      sw     = (m_mode == M_DRAIN) || (m_mode == M_ARM);
      if (m_mode == M_IDLE) begin
         m_wait = 0;
         if (bus.i_cks_wr) begin m_cks = int'(bus.i_cks_wdata); m_fault = 0; end
         if (bus.i_tmr_en) m_mode = M_RUN;
      end else begin
         if (sw && bus.i_cks_wr) m_err = 1;
         if (!r && m_wait == TIMEOUT - 1) begin
            m_fault = 1; m_mode = M_IDLE; m_wait = 0;
         end else if (!bus.i_tmr_en) begin
            m_tick = r && (m_mode != M_ARM);
            if (sw) m_cks = m_pend;
            else if (bus.i_cks_wr) begin m_cks = int'(bus.i_cks_wdata); m_fault = 0; end
            m_mode = M_IDLE; m_wait = 0;
         end else begin
            m_wait = r ? 0 : m_wait + 1;
            case (m_mode)
               M_RUN: begin
                  m_tick = r;
                  if (bus.i_cks_wr && int'(bus.i_cks_wdata) != m_cks) begin
                     m_pend = int'(bus.i_cks_wdata); m_mode = M_DRAIN; m_wait = 0;
                  end
               end
               M_DRAIN: if (r) begin m_tick = 1; m_cks = m_pend; m_mode = M_ARM; end
               M_ARM:   if (r) m_mode = M_RUN;
               default: ;
            endcase
         end
      end
   endtask

   task automatic cycle(input logic en, input logic wr, input logic [1:0] wd);
      exp_t e;
      bus.i_tmr_en    = en;
      bus.i_cks_wr    = wr;
      bus.i_cks_wdata = wd;
      bus.i_clk_in    = div_clocks(phase) & ~stall_mask;
      @(posedge sys_clk);
      model_step();
      e.cnt_en    = m_tick;
      e.cks_cur   = 2'(m_cks);
      e.sw_busy   = (m_mode == M_DRAIN) || (m_mode == M_ARM);
      e.wr_err    = m_err;
      e.clk_fault = m_fault;
      exp_q.push_back(e);
      #1;
      phase++;
   endtask

   task automatic run(input int n, input logic en);
      for (int i = 0; i < n; i++) cycle(en, 1'b0, 2'd0);
   endtask

   // Monitor: compares every DUT output sample against the queued expectation.
   initial begin
      exp_t e;
      int   mon_cyc = 0;
      int   last_tick = -1;
      forever begin
         @(negedge sys_clk);
         mon_cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cnt_en",    8'(bus.o_cnt_en),    8'(e.cnt_en));
            check("cks_cur",   8'(bus.o_cks_cur),   8'(e.cks_cur));
            check("sw_busy",   8'(bus.o_sw_busy),   8'(e.sw_busy));
            check("wr_err",    8'(bus.o_wr_err),    8'(e.wr_err));
            check("clk_fault", 8'(bus.o_clk_fault), 8'(e.clk_fault));
            if (bus.o_cnt_en === 1'b1) begin
               tick_cnt++;
               if (last_tick >= 0) check("tick_gap_ge2", 8'(mon_cyc - last_tick >= 2), 8'd1);
               last_tick = mon_cyc;
            end
         end
      end
   end

   initial begin
      int t0;
      sys_rst_n = 1'b0;
      // Reset, then div2 at 2-cycle spacing.
      run(3, 1'b0);
      sys_rst_n = 1'b1;
      cycle(1'b0, 1'b1, 2'd0);
      run(2, 1'b1);
      t0 = tick_cnt;
      run(20, 1'b1);
      check("div2_pulses_in_20", 8'(tick_cnt - t0), 8'd10);
      // Source 3 from IDLE.
      run(2, 1'b0);
      cycle(1'b1, 1'b1, 2'd3);
      run(100, 1'b1);
      // Back to 0, then switch 0 -> 2 on the fly.
      run(1, 1'b0);
      cycle(1'b0, 1'b1, 2'd0);
      run(10, 1'b1);
      cycle(1'b1, 1'b1, 2'd2);
      run(60, 1'b1);
      // Switch to 3, second write while busy is rejected.
      cycle(1'b1, 1'b1, 2'd3);
      cycle(1'b1, 1'b1, 2'd1);
      run(80, 1'b1);
      // Stall source 3 until timeout, then clear the fault from IDLE.
      stall_mask = 4'b1000;
      run(80, 1'b1);
      stall_mask = 4'b0000;
      cycle(1'b0, 1'b1, 2'd1);
      run(12, 1'b1);
      // Disable during drain, then reset mid-run.
      cycle(1'b1, 1'b1, 2'd2);
      cycle(1'b0, 1'b0, 2'd0);
      run(3, 1'b0);
      run(40, 1'b1);
      sys_rst_n = 1'b0;
      run(2, 1'b1);
      sys_rst_n = 1'b1;
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) stall_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) stall_mask = 4'b0000;
         sys_rst_n = ($urandom_range(0, 499) != 0);
         cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0),
               2'($urandom_range(0, 3)));
      end
      sys_rst_n = 1'b1;
      run(2, 1'b0);
      @(negedge sys_clk);
      #1;
      check("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
